mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

- Bus initiator that drives the image data memory.
- Accepts word or byte load/store requests on a valid/ready channel.
- Serialises word stores into four big-endian byte writes on the memory's active-low byte write port, and captures word loads from the memory's negedge-updated 32-bit read port.
- Sits between the filter datapath/controller and the data memory, and is the only writer of that memory.

## Interface

- ADDR_W, 32, width of byte address
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; equals (state == IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  1  0 = byte, 1 = word (loads are always word; ignored for loads)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; byte store uses [7:0]
- rsp_valid  out  1  response pending
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load data; 0 for store acks
- mem_a  out  ADDR_W  memory address
- mem_din  out  8  memory write byte
- mem_we_n  out  1  memory write enable, active low; memory commits on posedge while low
- mem_do  in  32  memory word read data; memory updates it on negedge from mem_a

## Operation

- States:
  - IDLE: req_ready = 1. On req_valid, either:
    - Store: go to WRITE. Load base = req_addr, cnt = 0, and drive the first byte. That byte is req_wdata[31:24] for a word store, or req_wdata[7:0] for a byte store.
    - Load: go to READ. Load mem_a = req_addr and keep mem_we_n = 1.
  - WRITE: mem_we_n = 0, mem_a = base + cnt, mem_din = the byte for cnt (cnt 0..3 → [31:24], [23:16], [15:8], [7:0]).
    - Each posedge commits one byte and increments cnt.
    - After the last byte (cnt 3 for a word, cnt 0 for a byte), registered mem_we_n returns to 1, rsp_rdata = 0, and the state goes to RESP.
  - READ: one cycle. At the next posedge, capture mem_do into rsp_rdata and go to RESP.
  - RESP: rsp_valid = 1; rsp_rdata is held stable. When rsp_ready = 1, go to IDLE.
- Registered memory outputs: mem_a, mem_din and mem_we_n are all flops; no combinational path from req_* to mem_*.
- Address arithmetic: base + cnt is modulo 2^ADDR_W; 0xFFFFFFFF wraps to 0x00000000.
- Outside WRITE, mem_we_n = 1 always.
- No alignment check: unaligned word accesses are legal and byte-exact.
- Requests presented outside IDLE are ignored. The requester must hold them until req_ready.

## Timing

- Reset values (asynchronous, while rst_n = 0): state IDLE, cnt 0, mem_we_n 1, mem_a 0, mem_din 0, rsp_valid 0, rsp_rdata 0.
  - req_ready reads 1, but no request is accepted until the first posedge with rst_n = 1.
- Word store:
  - Accepted at posedge T; the bytes commit at posedges T+1 to T+4.
  - mem_we_n is low from after T until after T+4.
  - rsp_valid rises after T+4.
- Byte store: commits at T+1; rsp_valid rises after T+1.
- Load:
  - mem_a is valid after T; the memory updates mem_do at the negedge between T and T+1.
  - The capture happens at T+1, so rsp_valid rises after T+1 (latency 1).
- A response handshake at posedge R sets req_ready = 1 after R. The earliest next acceptance is R+1, so throughput is at most 1 request per (latency + 2) cycles.
- rsp_valid is held indefinitely while rsp_ready = 0.
- Reset mid-WRITE:
  - mem_we_n goes to 1 asynchronously.
  - Bytes already committed stay in memory; the remaining bytes are not written.
  - No response is produced.

## Structure

- Shared package mem_seq_pkg holds:
  - the state enum (IDLE, WRITE, READ, RESP)
  - the size encodings SIZE_BYTE = 0 and SIZE_WORD = 1
  - the constant WORD_BYTES = 4
- No sub-module. The byte-select mux, counter and FSM stay in one module.

## Test plan

- Word store 0xDEADBEEF at 0x10:
  - mem_we_n low for exactly 4 cycles.
  - Memory bytes 0x10..0x13 become DE, AD, BE, EF.
  - One rsp_valid with rsp_rdata = 0.
- Word load at 0x10 after that store:
  - rsp_rdata = 0xDEADBEEF.
  - rsp_valid 1 cycle after acceptance.
- Byte store 0x...5A at 0x21 with size = byte:
  - Single write cycle.
  - Byte 0x21 = 5A; bytes 0x20 and 0x22 unchanged.
- Word store at 0xFFFFFFFE with 0x11223344 (ADDR_W = 32):
  - mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Backpressure: hold rsp_ready = 0 for 10 cycles:
  - rsp_valid and rsp_rdata stay stable.
  - req_ready stays 0 and a new req_valid is not accepted.
  - rsp_ready = 1 → IDLE next cycle.
- Assert rst_n = 0 after the second byte of a word store:
  - mem_we_n = 1 immediately, no response.
  - Only the first two bytes are changed in memory.
  - Outputs equal the reset values.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// ============================================================================
//  Module      : mem_seq_pkg
//  Description : Shared types and constants for the memory access sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic SIZE_BYTE  = 1'b0;
  localparam logic SIZE_WORD  = 1'b1;
  localparam int   WORD_BYTES = 4;

  // Big-endian byte lane: index 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] data, input logic [1:0] idx);
    return data[31 - 8*int'(idx) -: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
//  Module      : mem_access_sequencer
//  Description : Serialises word/byte stores into big-endian byte writes and
//                captures word loads from the image data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_din,
  output logic              mem_we_n,
  input  logic [31:0]       mem_do
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_size, w_size_nxt;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
  logic [7:0]        r_mem_din, w_mem_din_nxt;
  logic              r_mem_we_n, w_mem_we_n_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic [1:0]        w_cnt_inc;
  logic              w_last;

  assign w_cnt_inc = r_cnt + 2'd1;
  assign w_last    = (r_size == SIZE_BYTE) || (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_base     <= '0;
      r_wdata    <= 32'd0;
      r_size     <= SIZE_BYTE;
      r_mem_a    <= '0;
      r_mem_din  <= 8'd0;
      r_mem_we_n <= 1'b1;
      r_rdata    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_base     <= w_base_nxt;
      r_wdata    <= w_wdata_nxt;
      r_size     <= w_size_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_din  <= w_mem_din_nxt;
      r_mem_we_n <= w_mem_we_n_nxt;
      r_rdata    <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = req_write ? WRITE : READ;
      WRITE:   if (w_last) w_state_nxt = RESP;
      READ:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-side values are computed here one cycle ahead so the pins are flops.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_base_nxt     = r_base;
    w_wdata_nxt    = r_wdata;
    w_size_nxt     = r_size;
    w_mem_a_nxt    = r_mem_a;
    w_mem_din_nxt  = r_mem_din;
    w_mem_we_n_nxt = 1'b1;
    w_rdata_nxt    = r_rdata;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_base_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          w_size_nxt  = req_size;
          w_cnt_nxt   = 2'd0;
          w_mem_a_nxt = req_addr;
          if (req_write) begin
            w_mem_din_nxt  = (req_size == SIZE_WORD) ? word_byte(req_wdata, 2'd0)
                                                     : req_wdata[7:0];
            w_mem_we_n_nxt = 1'b0;
          end
        end
      end
      WRITE: begin
        if (w_last) begin
          w_rdata_nxt = 32'd0;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_mem_a_nxt    = r_base + ADDR_W'(w_cnt_inc);
          w_mem_din_nxt  = word_byte(r_wdata, w_cnt_inc);
          w_mem_we_n_nxt = 1'b0;
        end
      end
      READ:    w_rdata_nxt = mem_do;
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_rdata = r_rdata;
    mem_a     = r_mem_a;
    mem_din   = r_mem_din;
    mem_we_n  = r_mem_we_n;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
//  Module      : tb_mem_access_sequencer
//  Description : Self-checking bench with a byte-level memory and a
//                transaction-level reference model of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;
  logic        mem_we_n;
  logic [31:0] mem_do = 32'd0;

  int tests = 0;
  int fails = 0;
  int we_low_cnt = 0;

  logic [7:0]  mem     [bit [31:0]];
  logic [7:0]  ref_mem [bit [31:0]];
  logic [39:0] exp_wr[$];
  logic [31:0] exp_rsp[$];

  mem_access_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_a(mem_a), .mem_din(mem_din), .mem_we_n(mem_we_n), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Memory: commits on posedge while we_n low, read port refreshed on negedge.
  always @(posedge clk) if (!mem_we_n) mem[mem_a] = mem_din;
  always @(negedge clk)
    mem_do <= {mem_byte(mem_a), mem_byte(mem_a + 32'd1),
               mem_byte(mem_a + 32'd2), mem_byte(mem_a + 32'd3)};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (rst_n) begin
      if (!mem_we_n) begin
        we_low_cnt++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h byte %h expected no write", mem_a, mem_din);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", mem_a, e[39:8]);
          check("wr_byte", {24'h0, mem_din}, {24'h0, e[7:0]});
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got rdata %h expected no response", rsp_rdata);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_rsp[0]);
          if (rsp_ready) void'(exp_rsp.pop_front());
        end
      end
    end
  end

  // Records the model's view of the transaction, then presents it for one edge.
  task automatic issue(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    if (w) begin
      for (int i = 0; i < (s ? 4 : 1); i++) begin
        logic [7:0] b;
        b = s ? d[31 - 8*i -: 8] : d[7:0];
        exp_wr.push_back({a + 32'(i), b});
        ref_mem[a + 32'(i)] = b;
      end
      exp_rsp.push_back(32'd0);
    end else begin
      exp_rsp.push_back({ref_byte(a), ref_byte(a + 32'd1), ref_byte(a + 32'd2), ref_byte(a + 32'd3)});
    end
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] data);
    lat = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    data = rsp_rdata;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_within_bound", {31'd0, lat < 20}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, w0;
    logic [31:0] d, held;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    mem[32'h20] = 8'h11; mem[32'h22] = 8'h33;
    ref_mem[32'h20] = 8'h11; ref_mem[32'h22] = 8'h33;

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mem_we_n", {31'd0, mem_we_n}, 32'd1);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_din", {24'd0, mem_din}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Word store, big-endian
    w0 = we_low_cnt;
    issue(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    wait_rsp(lat, d);
    check("wstore_latency", lat, 4);
    check("wstore_we_cycles", we_low_cnt - w0, 4);
    check("wstore_ack", d, 32'd0);
    check("wstore_mem", {mem_byte(32'h10), mem_byte(32'h11), mem_byte(32'h12), mem_byte(32'h13)}, 32'hDEADBEEF);

    // Word load back
    issue(1'b0, 1'b1, 32'h10, 32'h0);
    wait_rsp(lat, d);
    check("load_latency", lat, 1);
    check("load_data", d, 32'hDEADBEEF);

    // Byte store leaves neighbours alone
    w0 = we_low_cnt;
    issue(1'b1, 1'b0, 32'h21, 32'h1234565A);
    wait_rsp(lat, d);
    check("bstore_latency", lat, 1);
    check("bstore_we_cycles", we_low_cnt - w0, 1);
    check("bstore_mem", {8'h0, mem_byte(32'h20), mem_byte(32'h21), mem_byte(32'h22)}, 32'h00115A33);

    // Address wrap
    w0 = we_low_cnt;
    issue(1'b1, 1'b1, 32'hFFFFFFFE, 32'h11223344);
    wait_rsp(lat, d);
    check("wrap_we_cycles", we_low_cnt - w0, 4);
    check("wrap_mem", {mem_byte(32'hFFFFFFFE), mem_byte(32'hFFFFFFFF), mem_byte(32'h0), mem_byte(32'h1)}, 32'h11223344);

    // Unaligned load across written and unwritten bytes
    issue(1'b0, 1'b1, 32'h11, 32'h0);
    wait_rsp(lat, d);
    check("unaligned_load", d, 32'hADBEEF00);

    // Backpressure with a competing request held high
    issue(1'b0, 1'b1, 32'h20, 32'h0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    held = rsp_rdata;
    check("bp_data", held, 32'h115A3300);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 32'h80; req_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_stable", rsp_rdata, held);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_no_write", {24'd0, mem_byte(32'h80)}, 32'd0);

    // Reset after the second byte of a word store
    check("mid_req_ready", {31'd0, req_ready}, 32'd1);
    exp_wr.push_back({32'h40, 8'hCA}); exp_wr.push_back({32'h41, 8'hFE});
    ref_mem[32'h40] = 8'hCA; ref_mem[32'h41] = 8'hFE;
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_we_n", {31'd0, mem_we_n}, 32'd1);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_mem_a", mem_a, 32'd0);
    check("mid_mem_din", {24'd0, mem_din}, 32'd0);
    check("mid_rsp_rdata", rsp_rdata, 32'd0);
    check("mid_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_pending_writes", exp_wr.size(), 0);
    check("mid_mem", {mem_byte(32'h40), mem_byte(32'h41), mem_byte(32'h42), mem_byte(32'h43)}, 32'hCAFE0000);
    issue(1'b0, 1'b1, 32'h40, 32'h0);
    wait_rsp(lat, d);
    check("mid_load", d, 32'hCAFE0000);

    repeat (3) @(posedge clk);
    #1;
    check("end_pending_rsp", exp_rsp.size(), 0);
    check("end_pending_wr", exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
